// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback over shared PC/IR/ALU/memory resources and drives all datapath selects.
module rv_multicycle_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  result_src,
  output logic [2:0]  imm_src,
  output logic        illegal_instr,
  output logic        mem_timeout,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRLINK = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  state_t state, state_nx;
  logic [WAIT_W-1:0] wait_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       illegal_dec;
  logic [2:0] alu_dec;
  logic       mem_state;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    illegal_dec = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR: illegal_dec = 1'b0;
      OP_R, OP_I:                         illegal_dec = (funct3 == 3'b011);
      OP_BR:                              illegal_dec = (funct3[2:1] != 2'b00);
      default:                            illegal_dec = 1'b1;
    endcase
  end

  // instr[30] selects sub only for R-type; on I-type it is part of the immediate.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_dec = ALU_AND;
      3'b110:  alu_dec = ALU_OR;
      3'b100:  alu_dec = ALU_XOR;
      3'b010:  alu_dec = ALU_SLT;
      3'b001:  alu_dec = ALU_SLL;
      3'b101:  alu_dec = ALU_SRL;
      default: alu_dec = ALU_ADD;
    endcase
  end

  // Handshake: mem_req stays high in FETCH/MEMREAD/MEMWRITE until a cycle with
  // mem_ready=1 completes the access; mem_ready in the first mem_req cycle is a
  // zero-wait access, and mem_ready is ignored in every other state.
  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);

  logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] src_a_c, src_b_c, res_c;
  logic [2:0] alu_c, imm_c;

  always_comb begin
    state_nx    = state;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    adr_src_c   = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    src_a_c     = 2'b00;
    src_b_c     = 2'b00;
    alu_c       = ALU_ADD;
    res_c       = 2'b00;
    imm_c       = 3'b000;
    case (state)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        src_b_c    = 2'b10;
        res_c      = 2'b10;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        // Precompute OldPC+imm as a branch/jal target while the opcode is decoded.
        src_a_c = 2'b01;
        src_b_c = 2'b01;
        imm_c   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
        if (illegal_dec) begin
          state_nx = S_FETCH;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_nx = S_MEMADR;
            OP_R:              state_nx = S_EXECR;
            OP_I:              state_nx = S_EXECI;
            OP_BR:             state_nx = S_BRANCH;
            OP_JAL:            state_nx = S_JAL;
            OP_JALR:           state_nx = S_JALR;
            default:           state_nx = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        src_a_c  = 2'b10;
        src_b_c  = 2'b01;
        imm_c    = (opcode == OP_STORE) ? 3'b001 : 3'b000;
        state_nx = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        res_c       = 2'b01;
        reg_write_c = 1'b1;
        state_nx    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem_ready) state_nx = S_FETCH;
      end
      S_EXECR: begin
        src_a_c  = 2'b10;
        src_b_c  = 2'b00;
        alu_c    = alu_dec;
        state_nx = S_ALUWB;
      end
      S_EXECI: begin
        src_a_c  = 2'b10;
        src_b_c  = 2'b01;
        alu_c    = alu_dec;
        state_nx = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_nx    = S_FETCH;
      end
      S_BRANCH: begin
        src_a_c    = 2'b10;
        alu_c      = ALU_SUB;
        pc_write_c = zero ^ funct3[0];
        state_nx   = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut; the ALU forms OldPC+4 for the link.
        src_a_c    = 2'b01;
        src_b_c    = 2'b10;
        pc_write_c = 1'b1;
        state_nx   = S_ALUWB;
      end
      S_JALR: begin
        src_a_c    = 2'b10;
        src_b_c    = 2'b01;
        res_c      = 2'b10;
        pc_write_c = 1'b1;
        state_nx   = S_JALRLINK;
      end
      S_JALRLINK: begin
        src_a_c     = 2'b01;
        src_b_c     = 2'b10;
        res_c       = 2'b10;
        reg_write_c = 1'b1;
        state_nx    = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      wait_cnt      <= '0;
      illegal_instr <= 1'b0;
      mem_timeout   <= 1'b0;
    end else begin
      state         <= state_nx;
      illegal_instr <= (state == S_DECODE) && illegal_dec;
      mem_timeout   <= mem_state && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
      // Saturates at MAX_WAIT so the timeout fires only once per stall.
      if (mem_state && !mem_ready) begin
        if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // The reset state is FETCH, so the decoded strobes are forced low while rst_n is low.
  assign mem_req    = rst_n & mem_req_c;
  assign mem_write  = rst_n & mem_write_c;
  assign adr_src    = rst_n & adr_src_c;
  assign ir_write   = rst_n & ir_write_c;
  assign pc_write   = rst_n & pc_write_c;
  assign reg_write  = rst_n & reg_write_c;
  assign alu_src_a  = rst_n ? src_a_c : 2'b00;
  assign alu_src_b  = rst_n ? src_b_c : 2'b00;
  assign alu_ctrl   = rst_n ? alu_c   : 3'b000;
  assign result_src = rst_n ? res_c   : 2'b00;
  assign imm_src    = rst_n ? imm_c   : 3'b000;
  assign state_o    = state;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: expected state traces are queued per
// instruction and popped each cycle; datapath strobes are checked per state.
module tb_rv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_ctrl, imm_src;
  logic        illegal_instr, mem_timeout;
  logic [3:0]  state_o;
  logic [23:0] all_outs;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  localparam logic [31:0] I_ADDI   = 32'h00500093;
  localparam logic [31:0] I_LW     = 32'h0000A103;
  localparam logic [31:0] I_SW     = 32'h0020A223;
  localparam logic [31:0] I_BNE    = 32'h00209063;
  localparam logic [31:0] I_SUB    = 32'h402081B3;
  localparam logic [31:0] I_AND    = 32'h0020F1B3;
  localparam logic [31:0] I_ADDIN  = 32'hFFF00093;
  localparam logic [31:0] I_JAL    = 32'h008000EF;
  localparam logic [31:0] I_JALR   = 32'h000100E7;
  localparam logic [31:0] I_BADBR  = 32'h00002063;
  localparam logic [31:0] I_SLTU   = 32'h0020B1B3;
  localparam logic [31:0] I_BADOP  = 32'h0000007F;

  // clock / reset
  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.MAX_WAIT(4), .WAIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .result_src(result_src),
    .imm_src(imm_src), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout),
    .state_o(state_o)
  );

  assign all_outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, alu_ctrl, result_src, imm_src,
                     illegal_instr, mem_timeout, state_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one cycle, inputs applied at the falling edge, state checked against the queue
  task automatic cyc(input logic rdy, input logic z);
    logic [3:0] exp_s;
    @(negedge clk);
    mem_ready = rdy;
    zero      = z;
    #1;
    exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
    check("state", {28'h0, state_o}, {28'h0, exp_s});
  endtask

  task automatic push4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int to_cnt;
    int to_first;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; instr = I_ADDI;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {8'h0, all_outs}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_mem_req", mem_req, 1);
    check("release_ir_write", ir_write, 1);
    check("release_state", state_o, 0);

    // addi x1,x0,5
    push4(1, 7, 8, 0);
    cyc(1, 0); check("addi_dec_imm", imm_src, 3'b010);
    cyc(1, 0); check("execi_imm", imm_src, 3'b000); check("execi_alu", alu_ctrl, 3'b000);
               check("execi_srcb", alu_src_b, 2'b01); check("execi_srca", alu_src_a, 2'b10);
    cyc(1, 0); check("aluwb_regw", reg_write, 1); check("aluwb_res", result_src, 2'b00);
    cyc(1, 0); check("fetch_pcw", pc_write, 1); check("no_illegal", illegal_instr, 0);
    instr = I_LW;

    // lw with a 3-cycle memory stall
    push4(1, 2, 3, 3); push4(3, 3, 4, 0);
    cyc(1, 0);
    cyc(1, 0); check("lw_memadr_imm", imm_src, 3'b000); check("lw_memadr_srca", alu_src_a, 2'b10);
    cyc(0, 0); check("lw_rd_req", mem_req, 1); check("lw_rd_adr", adr_src, 1);
    cyc(0, 0);
    cyc(0, 0); check("lw_rd_req_stall", mem_req, 1);
    cyc(1, 0); check("lw_rd_req_last", mem_req, 1); check("lw_no_timeout", mem_timeout, 0);
    cyc(1, 0); check("memwb_res", result_src, 2'b01); check("memwb_regw", reg_write, 1);
    cyc(1, 0);
    instr = I_SW;

    // sw
    push4(1, 2, 5, 0);
    cyc(1, 0);
    cyc(1, 0); check("sw_memadr_imm", imm_src, 3'b001);
    cyc(1, 0); check("sw_wr", mem_write, 1); check("sw_req", mem_req, 1); check("sw_adr", adr_src, 1);
    cyc(1, 0);
    instr = I_BNE;

    // bne, not equal -> taken
    exp_q.push_back(1); exp_q.push_back(9); exp_q.push_back(0);
    cyc(1, 0);
    cyc(1, 0); check("bne_taken_pcw", pc_write, 1); check("bne_alu", alu_ctrl, 3'b001);
    cyc(1, 0);
    // bne, equal -> not taken
    exp_q.push_back(1); exp_q.push_back(9); exp_q.push_back(0);
    cyc(1, 0);
    cyc(1, 1); check("bne_nottaken_pcw", pc_write, 0);
    cyc(1, 0);
    instr = I_SUB;

    push4(1, 6, 8, 0);
    cyc(1, 0);
    cyc(1, 0); check("sub_alu", alu_ctrl, 3'b001); check("execr_srcb", alu_src_b, 2'b00);
    cyc(1, 0); cyc(1, 0);
    instr = I_AND;

    push4(1, 6, 8, 0);
    cyc(1, 0);
    cyc(1, 0); check("and_alu", alu_ctrl, 3'b010);
    cyc(1, 0); cyc(1, 0);
    instr = I_ADDIN;

    // addi with instr[30]=1 must stay add
    push4(1, 7, 8, 0);
    cyc(1, 0);
    cyc(1, 0); check("addineg_alu", alu_ctrl, 3'b000);
    cyc(1, 0); cyc(1, 0);
    instr = I_JAL;

    push4(1, 10, 8, 0);
    cyc(1, 0); check("jal_dec_imm", imm_src, 3'b011);
    cyc(1, 0); check("jal_pcw", pc_write, 1); check("jal_srca", alu_src_a, 2'b01);
               check("jal_srcb", alu_src_b, 2'b10);
    cyc(1, 0); check("jal_link_regw", reg_write, 1); check("jal_link_pcw", pc_write, 0);
    cyc(1, 0);
    instr = I_JALR;

    push4(1, 11, 12, 0);
    cyc(1, 0); check("jalr_dec_imm", imm_src, 3'b010);
    cyc(1, 0); check("jalr_pcw", pc_write, 1); check("jalr_regw", reg_write, 0);
               check("jalr_res", result_src, 2'b10);
    cyc(1, 0); check("jalrlink_regw", reg_write, 1); check("jalrlink_pcw", pc_write, 0);
    cyc(1, 0);
    instr = I_BADBR;

    // illegal branch funct3, then illegal R-type funct3
    exp_q.push_back(1); exp_q.push_back(0);
    cyc(1, 0);
    cyc(1, 0); check("badbr_illegal", illegal_instr, 1);
    instr = I_SLTU;
    exp_q.push_back(1); exp_q.push_back(0);
    cyc(1, 0); check("illegal_one_cycle", illegal_instr, 0);
    cyc(1, 0); check("sltu_illegal", illegal_instr, 1);
    instr = I_BADOP;

    // opcode 0x7F, then a long FETCH stall
    exp_q.push_back(1);
    cyc(1, 0);
    to_cnt = 0;
    to_first = 0;
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(0);
      cyc(0, 0);
      if (i == 1) check("badop_illegal", illegal_instr, 1);
      if (i == 2) check("badop_illegal_off", illegal_instr, 0);
      if (mem_timeout === 1'b1) begin
        to_cnt++;
        if (to_first == 0) to_first = i;
      end
    end
    check("timeout_pulses", to_cnt, 1);
    check("timeout_cycle", to_first, 5);
    check("stall_req_held", mem_req, 1);

    // reset mid-stall
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_req", mem_req, 0);
    check("midreset_outputs", {8'h0, all_outs}, 32'h0);
    instr = I_ADDI;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("restart_req", mem_req, 1);
    check("restart_state", state_o, 0);
    exp_q.push_back(1); exp_q.push_back(7);
    cyc(1, 0);
    cyc(1, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
